// File: rtl/resp_tx_framer.sv
// Response packet framer: opcode, reserved, 16-bit length, then payload LSB-first.
// Upstream valid/ready accept in IDLE; byte-wide valid/ready stream toward UART TX.
module resp_tx_framer #(
  parameter int MAX_BYTES_P = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               opcode_i,
  input  logic [8*MAX_BYTES_P-1:0] result_i,
  input  logic [2:0]               payload_len_i,
  input  logic                     result_valid_i,
  output logic                     result_ready_o,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic [4:0]               state_o
);

  localparam int RW = 8 * MAX_BYTES_P;
  localparam logic [2:0] MAXL = 3'(MAX_BYTES_P);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    OPC  = 5'b00010,
    RSV  = 5'b00011,
    LSB  = 5'b00100,
    MSB  = 5'b00101,
    DATA = 5'b00110
  } state_t;

  state_t      state, state_d;
  logic [RW-1:0] res_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  data_d;
  logic        valid_d;
  logic        hs;
  logic        accept;
  logic [2:0]  len_eff;
  logic [2:0]  idx;
  logic [15:0] len16;
  logic [7:0]  byte_nxt;

  assign result_ready_o = (state == IDLE);
  assign busy_o  = (state != IDLE);
  assign state_o = state;
  assign hs      = valid_o && ready_i;
  assign accept  = result_valid_i && result_ready_o;
  assign len_eff = (payload_len_i > MAXL) ? MAXL : payload_len_i;
  assign len16   = 16'd4 + 16'(len_q);

  // Byte that follows the current one: byte 0 after MSB, else cnt+1.
  assign idx      = (state == DATA) ? cnt_q + 3'd1 : 3'd0;
  assign byte_nxt = 8'(res_q >> {idx, 3'b000});

  always_comb begin
    state_d = state;
    data_d  = data_o;
    valid_d = valid_o;
    cnt_d   = cnt_q;
    unique case (state)
      IDLE: begin
        valid_d = 1'b0;
        if (result_valid_i) begin
          state_d = OPC;
          data_d  = opcode_i;
          valid_d = 1'b1;
        end
      end
      OPC: if (hs) begin
        state_d = RSV;
        data_d  = 8'h00;
      end
      RSV: if (hs) begin
        state_d = LSB;
        data_d  = len16[7:0];
      end
      LSB: if (hs) begin
        state_d = MSB;
        data_d  = len16[15:8];
      end
      MSB: if (hs) begin
        if (len_q != 3'd0) begin
          state_d = DATA;
          data_d  = byte_nxt;
          cnt_d   = 3'd0;
        end else begin
          state_d = IDLE;
          data_d  = 8'h00;
          valid_d = 1'b0;
        end
      end
      DATA: if (hs) begin
        if (cnt_q == len_q - 3'd1) begin
          state_d = IDLE;
          data_d  = 8'h00;
          valid_d = 1'b0;
          cnt_d   = 3'd0;
        end else begin
          cnt_d  = cnt_q + 3'd1;
          data_d = byte_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        data_d  = 8'h00;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      cnt_q   <= 3'd0;
      res_q   <= '0;
      len_q   <= 3'd0;
    end else begin
      state   <= state_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        res_q <= result_i;
        len_q <= len_eff;
      end
    end
  end

endmodule

// File: tb/tb_resp_tx_framer.sv
// Directed bench for resp_tx_framer: inputs driven and outputs sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_resp_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  opcode_i;
  logic [31:0] result_i;
  logic [2:0]  payload_len_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic [4:0]  state_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  resp_tx_framer #(.MAX_BYTES_P(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode_i       (opcode_i),
    .result_i       (result_i),
    .payload_len_i  (payload_len_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .busy_o         (busy_o),
    .state_o        (state_o)
  );

  // Present one result for a single edge; returns at the falling edge
  // where the opcode byte should be visible.
  task automatic send(input logic [7:0] o, input logic [31:0] r,
                      input logic [2:0] l);
    opcode_i       = o;
    result_i       = r;
    payload_len_i  = l;
    result_valid_i = 1'b1;
    @(negedge clk);
    result_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvec++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin
      nerr++;
      $display("FAIL reset_out: v=%b d=%h want v=0 d=00", valid_o, data_o);
    end
    nvec++;
    if (result_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_rdy: rdy=%b busy=%b want 1 0",
               result_ready_o, busy_o);
    end
    nvec++;
    if (state_o !== 5'b00001) begin
      nerr++;
      $display("FAIL reset_state: got %b want 00001", state_o);
    end
    @(negedge clk);
  endtask

  task automatic test_full_packet();
    logic [7:0] e [8];
    e = '{8'h5A, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ready_i = 1'b1;
    send(8'h5A, 32'hDEADBEEF, 3'd4);
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== e[i]) begin
        nerr++;
        $display("FAIL full_byte%0d: v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, e[i]);
      end
      @(negedge clk);
    end
    nvec++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL full_end: busy=%b v=%b want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [8];
    int k;
    int st;
    e = '{8'h5A, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    k = 0;
    st = 0;
    ready_i = 1'b1;
    send(8'h5A, 32'hDEADBEEF, 3'd4);
    for (int c = 0; c < 30 && k < 8; c++) begin
      if (valid_o && k == 2 && st < 3) begin
        ready_i = 1'b0;
        st++;
        nvec++;
        if (data_o !== 8'h08 || state_o !== 5'b00100) begin
          nerr++;
          $display("FAIL bp_stall%0d: d=%h st=%b want 08 00100",
                   st, data_o, state_o);
        end
      end else begin
        ready_i = 1'b1;
        if (valid_o) begin
          nvec++;
          if (data_o !== e[k]) begin
            nerr++;
            $display("FAIL bp_byte%0d: d=%h want %h", k, data_o, e[k]);
          end
          k++;
        end
      end
      @(negedge clk);
    end
    ready_i = 1'b1;
    nvec++;
    if (k != 8 || st != 3 || valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL bp_count: bytes=%0d stalls=%0d v=%b want 8 3 0",
               k, st, valid_o);
    end
  endtask

  task automatic test_lengths();
    logic [7:0] z [4];
    logic [7:0] c [8];
    z = '{8'hA5, 8'h00, 8'h04, 8'h00};
    c = '{8'h3C, 8'h00, 8'h08, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    ready_i = 1'b1;
    send(8'hA5, 32'h12345678, 3'd0);
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== z[i]) begin
        nerr++;
        $display("FAIL zero_byte%0d: v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, z[i]);
      end
      @(negedge clk);
    end
    nvec++;
    if (valid_o !== 1'b0 || state_o !== 5'b00001) begin
      nerr++;
      $display("FAIL zero_end: v=%b st=%b want 0 00001", valid_o, state_o);
    end
    send(8'h3C, 32'h01020304, 3'd7);
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== c[i]) begin
        nerr++;
        $display("FAIL clamp_byte%0d: v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, c[i]);
      end
      @(negedge clk);
    end
    nvec++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL clamp_end: v=%b busy=%b want 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e1 [5];
    logic [7:0] e2 [4];
    e1 = '{8'h11, 8'h00, 8'h05, 8'h00, 8'hC7};
    e2 = '{8'h22, 8'h00, 8'h04, 8'h00};
    ready_i = 1'b1;
    opcode_i = 8'h11;
    result_i = 32'h000000C7;
    payload_len_i = 3'd1;
    result_valid_i = 1'b1;
    @(negedge clk);
    opcode_i = 8'h22;
    result_i = 32'hFFFFFFFF;
    payload_len_i = 3'd0;
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== e1[i] || result_ready_o !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_p1_byte%0d: v=%b d=%h rdy=%b want 1 %h 0",
                 i, valid_o, data_o, result_ready_o, e1[i]);
      end
      @(negedge clk);
    end
    nvec++;
    if (valid_o !== 1'b0 || result_ready_o !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_gap: v=%b rdy=%b want 0 1", valid_o, result_ready_o);
    end
    @(negedge clk);
    result_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== e2[i]) begin
        nerr++;
        $display("FAIL b2b_p2_byte%0d: v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, e2[i]);
      end
      @(negedge clk);
    end
    nvec++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_end: v=%b busy=%b want 0 0", valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e [6];
    e = '{8'h77, 8'h00, 8'h08, 8'h00, 8'hD4, 8'hC3};
    ready_i = 1'b1;
    send(8'h77, 32'hA1B2C3D4, 3'd4);
    for (int i = 0; i < 6; i++) begin
      nvec++;
      if (valid_o !== 1'b1 || data_o !== e[i]) begin
        nerr++;
        $display("FAIL rmid_byte%0d: v=%b d=%h want v=1 d=%h",
                 i, valid_o, data_o, e[i]);
      end
      if (i == 5) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    nvec++;
    if (valid_o !== 1'b0 || state_o !== 5'b00001) begin
      nerr++;
      $display("FAIL rmid_drop: v=%b st=%b want 0 00001", valid_o, state_o);
    end
    @(negedge clk);
    nvec++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      nerr++;
      $display("FAIL rmid_trail: v=%b busy=%b want 0 0", valid_o, busy_o);
    end
    send(8'h99, 32'h0, 3'd0);
    nvec++;
    if (valid_o !== 1'b1 || data_o !== 8'h99) begin
      nerr++;
      $display("FAIL rmid_fresh: v=%b d=%h want v=1 d=99", valid_o, data_o);
    end
    repeat (4) @(negedge clk);
    nvec++;
    if (valid_o !== 1'b0 || state_o !== 5'b00001) begin
      nerr++;
      $display("FAIL rmid_end: v=%b st=%b want 0 00001", valid_o, state_o);
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode_i = 8'h00;
    result_i = 32'h0;
    payload_len_i = 3'd0;
    result_valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_packet();
    test_backpressure();
    test_lengths();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
